fan_pwm_driver: RTL and testbench



---
 rtl/fan_pwm_driver.sv | 146 ++++++++++++++
 tb/tb_fan_pwm_driver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fan_pwm_driver.sv
// Fixed-frequency fan PWM driver with boundary-aligned, saturating duty ramping.
// Optional kick-start at full duty from standstill when FAN_KICKSTART_EN is defined.
module fan_pwm_driver #(
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned DUTY_LOW     = 85,
  parameter int unsigned DUTY_MED     = 170,
  parameter int unsigned DUTY_HIGH    = 255,
  parameter int unsigned RAMP_STEP    = 8,
  parameter int unsigned KICK_PERIODS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          fan_speed_in,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty_out,
  output logic                at_target,
  output logic                kick_active
);

  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(RAMP_STEP);
  localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS+1)'(RAMP_STEP);

`ifdef FAN_KICKSTART_EN
  typedef enum logic [1:0] {IDLE = 2'd0, KICK = 2'd1, RUN = 2'd2} state_t;
  localparam int unsigned KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
  localparam logic [KW-1:0] KICK_LAST = KW'(KICK_PERIODS - 1);
  logic [KW-1:0] kick_cnt_reg, kick_cnt_next;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd2} state_t;
`endif

  state_t              state_reg, state_next;
  logic [1:0]          target_lvl_reg;
  logic [PWM_BITS-1:0] cnt_reg;
  logic [PWM_BITS-1:0] duty_cur_reg, duty_cur_next;
  logic [PWM_BITS-1:0] target_duty, ramp_duty, gap_up, gap_dn;
  logic                boundary;

  assign boundary = (cnt_reg == CNT_LAST);

  always_comb begin
    target_duty = '0;
    case (target_lvl_reg)
      2'b01:   target_duty = PWM_BITS'(DUTY_LOW);
      2'b10:   target_duty = PWM_BITS'(DUTY_MED);
      2'b11:   target_duty = PWM_BITS'(DUTY_HIGH);
      default: target_duty = '0;
    endcase
  end

  // Gaps are only meaningful in the direction selected below; the step
  // comparison is done one bit wider so a large RAMP_STEP cannot wrap.
  assign gap_up = target_duty - duty_cur_reg;
  assign gap_dn = duty_cur_reg - target_duty;

  always_comb begin
    ramp_duty = duty_cur_reg;
    if (duty_cur_reg < target_duty) begin
      ramp_duty = ({1'b0, gap_up} > STEP_W) ? duty_cur_reg + STEP : target_duty;
    end else if (duty_cur_reg > target_duty) begin
      ramp_duty = ({1'b0, gap_dn} > STEP_W) ? duty_cur_reg - STEP : target_duty;
    end
  end

  always_comb begin
    state_next    = state_reg;
    duty_cur_next = duty_cur_reg;
`ifdef FAN_KICKSTART_EN
    kick_cnt_next = kick_cnt_reg;
`endif
    if (boundary) begin
      case (state_reg)
        IDLE: begin
          if (target_duty != '0) begin
`ifdef FAN_KICKSTART_EN
            state_next    = KICK;
            kick_cnt_next = '0;
`else
            // Ramp starts from zero on the same boundary that leaves IDLE.
            state_next    = RUN;
            duty_cur_next = ramp_duty;
`endif
          end
        end
`ifdef FAN_KICKSTART_EN
        KICK: begin
          if (target_duty == '0) begin
            state_next    = IDLE;
            duty_cur_next = '0;
          end else if (kick_cnt_reg == KICK_LAST) begin
            state_next    = RUN;
            duty_cur_next = target_duty;
          end else begin
            kick_cnt_next = kick_cnt_reg + 1'b1;
          end
        end
`endif
        RUN: begin
          if (target_duty == '0) begin
            state_next    = IDLE;
            duty_cur_next = '0;
          end else begin
            duty_cur_next = ramp_duty;
          end
        end
        default: begin
          state_next    = IDLE;
          duty_cur_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      target_lvl_reg <= 2'b00;
      cnt_reg        <= '0;
      duty_cur_reg   <= '0;
`ifdef FAN_KICKSTART_EN
      kick_cnt_reg   <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      target_lvl_reg <= fan_speed_in;
      cnt_reg        <= boundary ? '0 : cnt_reg + 1'b1;
      duty_cur_reg   <= duty_cur_next;
`ifdef FAN_KICKSTART_EN
      kick_cnt_reg   <= kick_cnt_next;
`endif
    end
  end

`ifdef FAN_KICKSTART_EN
  assign kick_active = (state_reg == KICK);
`else
  assign kick_active = 1'b0;
`endif

  assign duty_out  = kick_active ? MAX : duty_cur_reg;
  assign pwm_out   = (cnt_reg < duty_out);
  assign at_target = (duty_out == target_duty) && !kick_active;

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Randomized self-checking bench for fan_pwm_driver against a cycle-level
// integer reference model; honours FAN_KICKSTART_EN if defined.
module tb_fan_pwm_driver;

  localparam int MAXV   = 15;
  localparam int D_LOW  = 5;
  localparam int D_MED  = 10;
  localparam int D_HIGH = 15;
  localparam int STEP   = 2;
  localparam int KP     = 2;
`ifdef FAN_KICKSTART_EN
  localparam bit KICK_EN = 1'b1;
`else
  localparam bit KICK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] fan_speed_in = 2'b00;
  logic       pwm_out;
  logic [3:0] duty_out;
  logic       at_target;
  logic       kick_active;

  int chk_cnt = 0;
  int err_cnt = 0;

  // reference model: position in period, applied duty, kick periods left
  int m_phase, m_duty, m_kick_left, m_lvl;
  bit m_on;

  fan_pwm_driver #(
    .PWM_BITS(4), .DUTY_LOW(D_LOW), .DUTY_MED(D_MED), .DUTY_HIGH(D_HIGH),
    .RAMP_STEP(STEP), .KICK_PERIODS(KP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .fan_speed_in(fan_speed_in),
    .pwm_out(pwm_out), .duty_out(duty_out),
    .at_target(at_target), .kick_active(kick_active)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input int exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lvl_duty(input int lvl);
    case (lvl)
      1:       return D_LOW;
      2:       return D_MED;
      3:       return D_HIGH;
      default: return 0;
    endcase
  endfunction

  function automatic int approach(input int d, input int t);
    if (d < t) return d + (((t - d) < STEP) ? (t - d) : STEP);
    if (d > t) return d - (((d - t) < STEP) ? (d - t) : STEP);
    return d;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_duty = 0; m_kick_left = 0; m_lvl = 0; m_on = 1'b0;
  endtask

  task automatic model_step();
    int t;
    t = lvl_duty(m_lvl);
    if (m_phase == MAXV - 1) begin
      if (t == 0) begin
        m_duty = 0; m_on = 1'b0; m_kick_left = 0;
      end else if (!m_on) begin
        m_on = 1'b1;
        if (KICK_EN) m_kick_left = KP;
        else         m_duty = approach(0, t);
      end else if (m_kick_left > 0) begin
        m_kick_left--;
        if (m_kick_left == 0) m_duty = t;
      end else begin
        m_duty = approach(m_duty, t);
      end
      m_phase = 0;
    end else begin
      m_phase++;
    end
    m_lvl = int'(fan_speed_in);
  endtask

  task automatic check_all();
    int ed;
    ed = (m_kick_left > 0) ? MAXV : m_duty;
    check_value("duty_out", duty_out, ed);
    check_value("pwm_out", pwm_out, (m_phase < ed) ? 1 : 0);
    check_value("at_target", at_target, ((ed == lvl_duty(m_lvl)) && (m_kick_left == 0)) ? 1 : 0);
    check_value("kick_active", kick_active, (m_kick_left > 0) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
    check_all();
  endtask

  task automatic apply(input int lvl, input int n);
    fan_speed_in = 2'(lvl);
    $display("apply level %0d for %0d cycles (duty %0d)", lvl, n, m_duty);
    repeat (n) tick();
  endtask

  task automatic reset_pulse();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_value("rst_pwm_async", pwm_out, 0);
    check_value("rst_duty_async", duty_out, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    $display("reset pulse released");
  endtask

  initial begin
    int hi;
    bit found;
    model_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    check_value("rst_at_target", at_target, 1);
    check_value("rst_kick", kick_active, 0);
    reset_n = 1'b1;

    apply(0, 40);
    check_value("idle_duty", duty_out, 0);

    apply(3, 15 * 12);
    check_value("high_duty", duty_out, 15);
    check_value("high_at_target", at_target, 1);
    hi = 0;
    repeat (15) begin tick(); hi += int'(pwm_out); end
    check_value("high_pwm_cnt", hi, 15);

    fan_speed_in = 2'b01;
    $display("apply level 1 until duty 9");
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = (m_duty == 9);
    end
    check_value("reach_duty9", found, 1);
    check_value("duty_at_9", duty_out, 9);
    apply(2, 15 * 4);
    check_value("reverse_duty10", duty_out, 10);

    apply(0, 20);
    check_value("fast_stop_duty", duty_out, 0);
    check_value("fast_stop_at", at_target, 1);

    apply(1, 20);
    check_value("kick_mid", kick_active, KICK_EN ? 1 : 0);
    apply(0, 20);
    check_value("kick_abort_duty", duty_out, 0);

    apply(2, 15 * 10);
    check_value("med_duty", duty_out, 10);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = (m_phase == 7);
    end
    check_value("mid_period_pwm", pwm_out, 1);
    reset_pulse();
    apply(3, 15 * 3);

    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 19) == 0) reset_pulse();
      apply(int'($urandom_range(0, 3)), int'($urandom_range(1, 45)));
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
